// File: rtl/serial_link_pkg.sv
// Shared types and the round-robin search used by the serial link arbiter.
package serial_link_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } link_state_t;

    // Returns the first set bit of req at or after ptr, wrapping modulo n.
    // Widths are sized for the largest supported requester count (16).
    function automatic logic [3:0] next_rr(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input int          n);
        logic [3:0] sel;
        logic       found;
        int         idx;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && !found && req[idx[3:0]]) begin
                sel   = idx[3:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/serial_link_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr.
module rr_pick
    import serial_link_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] sel,
    output logic            any
);

    assign sel = ID_W'(next_rr(16'(req), 4'(ptr), N));
    assign any = |req;

endmodule

// File: rtl/serial_link_arbiter.sv
// Round-robin shared deserializer: grants one serial channel per WIDTH-bit word.
module serial_link_arbiter
    import serial_link_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int ID_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic [N_CH-1:0]  serial_valid,
    input  logic [N_CH-1:0]  serial_data,
    output logic [N_CH-1:0]  grant,
    output logic             parallel_valid,
    output logic [WIDTH-1:0] parallel_data,
    output logic [ID_W-1:0]  parallel_id,
    output logic             word_abort
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [ID_W-1:0]  LAST_CH  = ID_W'(N_CH - 1);

    link_state_t      state_reg, state_next;
    logic [N_CH-1:0]  grant_reg, grant_next;
    logic [ID_W-1:0]  g_reg, g_next;
    logic [ID_W-1:0]  ptr_reg, ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] pdata_reg, pdata_next;
    logic [ID_W-1:0]  pid_reg, pid_next;
    logic             pvalid_reg, pvalid_next;
    logic             abort_reg, abort_next;

    logic [ID_W-1:0]  sel;
    logic             any_req;
    logic [N_CH-1:0]  sel_onehot;
    logic [ID_W-1:0]  ptr_after_g;

    rr_pick #(.N(N_CH), .ID_W(ID_W)) u_rr_pick (
        .req (req),
        .ptr (ptr_reg),
        .sel (sel),
        .any (any_req)
    );

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
        assign sel_onehot[gi] = (sel == ID_W'(gi));
    end

    assign ptr_after_g = (g_reg == LAST_CH) ? '0 : g_reg + ID_W'(1);

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        g_next      = g_reg;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_reg;
        shift_next  = shift_reg;
        pdata_next  = pdata_reg;
        pid_next    = pid_reg;
        pvalid_next = 1'b0;
        abort_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant_next = sel_onehot;
                    g_next     = sel;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // A dropped request wins over a bit arriving in the same cycle.
                if (!req[g_reg]) begin
                    abort_next = 1'b1;
                    cnt_next   = '0;
                    grant_next = '0;
                    ptr_next   = ptr_after_g;
                    state_next = IDLE;
                end else if (serial_valid[g_reg]) begin
                    if (cnt_reg == LAST_BIT) begin
                        pdata_next            = shift_reg;
                        pdata_next[WIDTH-1]   = serial_data[g_reg];
                        pid_next              = g_reg;
                        pvalid_next           = 1'b1;
                        cnt_next              = '0;
                        grant_next            = '0;
                        ptr_next              = ptr_after_g;
                        state_next            = IDLE;
                    end else begin
                        shift_next[cnt_reg] = serial_data[g_reg];
                        cnt_next            = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            g_reg      <= '0;
            ptr_reg    <= '0;
            cnt_reg    <= '0;
            shift_reg  <= '0;
            pdata_reg  <= '0;
            pid_reg    <= '0;
            pvalid_reg <= 1'b0;
            abort_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            g_reg      <= g_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            shift_reg  <= shift_next;
            pdata_reg  <= pdata_next;
            pid_reg    <= pid_next;
            pvalid_reg <= pvalid_next;
            abort_reg  <= abort_next;
        end
    end

    assign grant          = grant_reg;
    assign parallel_valid = pvalid_reg;
    assign parallel_data  = pdata_reg;
    assign parallel_id    = pid_reg;
    assign word_abort     = abort_reg;

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Directed bench for serial_link_arbiter (N_CH=4, WIDTH=8) with immediate assertions.
module tb_serial_link_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] serial_valid;
    logic [3:0] serial_data;
    logic [3:0] grant;
    logic       parallel_valid;
    logic [7:0] parallel_data;
    logic [1:0] parallel_id;
    logic       word_abort;

    int checks = 0;
    int errors = 0;

    serial_link_arbiter #(.N_CH(4), .WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .grant          (grant),
        .parallel_valid (parallel_valid),
        .parallel_data  (parallel_data),
        .parallel_id    (parallel_id),
        .word_abort     (word_abort)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one full word on channel ch, one bit per cycle, LSB first.
    task automatic send_word(input int ch, input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            serial_valid = 4'b0001 << ch;
            serial_data  = w[k] ? (4'b0001 << ch) : 4'b0000;
            tick();
        end
        serial_valid = 4'b0000;
        serial_data  = 4'b0000;
        $display("word sent ch=%0d data=%02h -> out valid=%0b data=%02h id=%0d",
                 ch, w, parallel_valid, parallel_data, parallel_id);
    endtask

    logic [7:0] rr_words [5];
    logic [7:0] gap_word;

    initial begin
        rr_words[0] = 8'h5A; rr_words[1] = 8'hC3; rr_words[2] = 8'h01;
        rr_words[3] = 8'h80; rr_words[4] = 8'h7E;
        gap_word = 8'hA5;

        rst = 1'b1; req = '0; serial_valid = '0; serial_data = '0;
        tick(); tick();
        check("rst_grant",  64'(grant), 64'h0);
        check("rst_pvalid", 64'(parallel_valid), 64'h0);
        check("rst_pdata",  64'(parallel_data), 64'h0);
        check("rst_pid",    64'(parallel_id), 64'h0);
        check("rst_abort",  64'(word_abort), 64'h0);
        rst = 1'b0;

        // Single requester on channel 2
        req = 4'b0100;
        tick();
        check("single_grant", 64'(grant), 64'h4);
        send_word(2, 8'h4D);
        check("single_pvalid", 64'(parallel_valid), 64'h1);
        check("single_pdata",  64'(parallel_data), 64'h4D);
        check("single_pid",    64'(parallel_id), 64'h2);
        check("single_grant_drop", 64'(grant), 64'h0);
        check("single_noabort", 64'(word_abort), 64'h0);
        req = 4'b0000;
        tick();
        check("single_pulse_end", 64'(parallel_valid), 64'h0);
        check("single_pdata_hold", 64'(parallel_data), 64'h4D);

        // Round-robin with everyone requesting, starting from pointer 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        check("rr_grant0", 64'(grant), 64'h1);
        for (int i = 0; i < 5; i++) begin
            send_word(i % 4, rr_words[i]);
            check("rr_pvalid", 64'(parallel_valid), 64'h1);
            check("rr_pdata",  64'(parallel_data), 64'(rr_words[i]));
            check("rr_pid",    64'(parallel_id), 64'(i % 4));
            check("rr_idle",   64'(grant), 64'h0);
            if (i == 4) req = 4'b0000;
            tick();
            check("rr_pulse_end", 64'(parallel_valid), 64'h0);
            if (i < 4) check("rr_next_grant", 64'(grant), 64'(4'b0001 << ((i + 1) % 4)));
        end

        // Channel 1 with strobes every other cycle while ch0/ch3 strobe ones
        req = 4'b0010;
        tick();
        check("gap_grant", 64'(grant), 64'h2);
        for (int k = 0; k < 8; k++) begin
            serial_valid = 4'b1011;
            serial_data  = gap_word[k] ? 4'b1011 : 4'b1001;
            tick();
            if (k < 7) begin
                serial_valid = 4'b1001;
                serial_data  = 4'b1111;
                tick();
            end
        end
        serial_valid = '0; serial_data = '0;
        $display("gapped word ch=1 sent=%02h -> out valid=%0b data=%02h id=%0d",
                 gap_word, parallel_valid, parallel_data, parallel_id);
        check("gap_pvalid", 64'(parallel_valid), 64'h1);
        check("gap_pdata",  64'(parallel_data), 64'hA5);
        check("gap_pid",    64'(parallel_id), 64'h1);
        req = 4'b0000;
        tick();

        // Channel 3 aborts after three bits; pointer then wraps to 0
        req = 4'b1000;
        tick();
        check("abort_grant3", 64'(grant), 64'h8);
        for (int k = 0; k < 3; k++) begin
            serial_valid = 4'b1000;
            serial_data  = 4'b1000;
            tick();
        end
        serial_valid = '0; serial_data = '0;
        req = 4'b0001;
        tick();
        $display("abort ch=3 after 3 bits -> abort=%0b valid=%0b", word_abort, parallel_valid);
        check("abort_pulse",   64'(word_abort), 64'h1);
        check("abort_novalid", 64'(parallel_valid), 64'h0);
        check("abort_grant0",  64'(grant), 64'h0);
        check("abort_pdata_hold", 64'(parallel_data), 64'hA5);
        check("abort_pid_hold",   64'(parallel_id), 64'h1);
        req = 4'b1001;
        tick();
        check("abort_pulse_end", 64'(word_abort), 64'h0);
        check("wrap_grant_ch0",  64'(grant), 64'h1);
        send_word(0, 8'h3C);
        check("clean_pvalid", 64'(parallel_valid), 64'h1);
        check("clean_pdata",  64'(parallel_data), 64'h3C);
        check("clean_pid",    64'(parallel_id), 64'h0);
        req = 4'b0000;
        tick();

        // Reset in the middle of a channel 0 word
        req = 4'b0001;
        tick();
        check("mid_grant", 64'(grant), 64'h1);
        for (int k = 0; k < 5; k++) begin
            serial_valid = 4'b0001;
            serial_data  = 4'b0001;
            tick();
        end
        rst = 1'b1;
        tick();
        check("mid_rst_grant",  64'(grant), 64'h0);
        check("mid_rst_pvalid", 64'(parallel_valid), 64'h0);
        check("mid_rst_pdata",  64'(parallel_data), 64'h0);
        check("mid_rst_pid",    64'(parallel_id), 64'h0);
        check("mid_rst_abort",  64'(word_abort), 64'h0);
        rst = 1'b0;
        serial_valid = '0; serial_data = '0;
        tick();
        check("post_rst_grant", 64'(grant), 64'h1);
        check("post_rst_abort", 64'(word_abort), 64'h0);
        send_word(0, 8'hFF);
        check("post_rst_pvalid", 64'(parallel_valid), 64'h1);
        check("post_rst_pdata",  64'(parallel_data), 64'hFF);
        check("post_rst_pid",    64'(parallel_id), 64'h0);
        req = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
